// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter with fixed-priority (highest index wins) and
// round-robin modes, presenting one grant at a time over valid/ready.
module prio_arb_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state, state_next;
  logic [W-1:0] ptr, ptr_next;
  logic [W-1:0] ptr_dec;
  logic [W-1:0] search_ptr;
  logic [W-1:0] search_idx;
  logic [W-1:0] idx_next;
  logic [N-1:0] onehot_next;
  logic         valid_next;
  logic         accept;
  int           cand;

  assign accept  = gnt_valid & gnt_ready;
  assign ptr_dec = (gnt_idx == '0) ? LAST : gnt_idx - 1'b1;
  // A back-to-back search must already see the pointer moved past the grant being accepted.
  assign search_ptr = (accept && mode) ? ptr_dec : ptr;
  assign busy = gnt_valid;

  // Later assignments win, so the loops end on the highest-priority candidate.
  always_comb begin
    search_idx = '0;
    cand       = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) search_idx = W'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = int'(search_ptr) - k;
        if (cand < 0) cand = cand + N;
        if (req[cand[W-1:0]]) search_idx = cand[W-1:0];
      end
    end
  end

  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    idx_next    = gnt_idx;
    onehot_next = gnt_onehot;
    valid_next  = gnt_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next              = GRANT;
          valid_next              = 1'b1;
          idx_next                = search_idx;
          onehot_next             = '0;
          onehot_next[search_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (mode) ptr_next = ptr_dec;
          if (|req) begin
            idx_next                = search_idx;
            onehot_next             = '0;
            onehot_next[search_idx] = 1'b1;
          end else begin
            state_next  = IDLE;
            valid_next  = 1'b0;
            idx_next    = '0;
            onehot_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= LAST;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      gnt_valid  <= valid_next;
      gnt_idx    <= idx_next;
      gnt_onehot <= onehot_next;
    end
  end

endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed bench for prio_arb_rr: an 8-way and a 5-way instance, with expected
// grants queued as stimulus is driven and checked one cycle later.
module tb_prio_arb_rr;

  typedef struct {
    logic sel;
    logic valid;
    logic chk_idx;
    int   idx;
  } exp_t;

  logic       clk;
  logic       rst_n_a, mode_a, ready_a;
  logic [7:0] req_a;
  logic       valid_a, busy_a;
  logic [2:0] idx_a;
  logic [7:0] oh_a;

  logic       rst_n_b, mode_b, ready_b;
  logic [4:0] req_b;
  logic       valid_b, busy_b;
  logic [2:0] idx_b;
  logic [4:0] oh_b;

  exp_t sb[$];
  int   tests;
  int   fails;

  prio_arb_rr #(.N(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .mode(mode_a), .req(req_a), .gnt_ready(ready_a),
    .gnt_valid(valid_a), .gnt_idx(idx_a), .gnt_onehot(oh_a), .busy(busy_a)
  );

  prio_arb_rr #(.N(5)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .mode(mode_b), .req(req_b), .gnt_ready(ready_b),
    .gnt_valid(valid_b), .gnt_idx(idx_b), .gnt_onehot(oh_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    exp_t       e;
    logic       ov, ob;
    int         oi;
    logic [7:0] ooh, eoh;
    e = sb.pop_front();
    if (e.sel) begin
      ov = valid_b; ob = busy_b; oi = int'(idx_b); ooh = {3'b000, oh_b};
    end else begin
      ov = valid_a; ob = busy_a; oi = int'(idx_a); ooh = oh_a;
    end
    eoh = e.valid ? (8'h01 << e.idx) : 8'h00;
    tests++;
    assert (ov === e.valid) else begin
      fails++;
      $error("[TB] FAIL %s valid: got %0b expected %0b", tag, ov, e.valid);
    end
    tests++;
    assert (ob === e.valid) else begin
      fails++;
      $error("[TB] FAIL %s busy: got %0b expected %0b", tag, ob, e.valid);
    end
    tests++;
    assert (ooh === eoh) else begin
      fails++;
      $error("[TB] FAIL %s onehot: got %h expected %h", tag, ooh, eoh);
    end
    if (e.valid || e.chk_idx) begin
      tests++;
      assert (oi === e.idx) else begin
        fails++;
        $error("[TB] FAIL %s idx: got %0d expected %0d", tag, oi, e.idx);
      end
    end
    if (e.sel) begin
      tests++;
      assert (oi < 5) else begin
        fails++;
        $error("[TB] FAIL %s idx range: got %0d expected below 5", tag, oi);
      end
    end
  endtask

  // Queue the expectation for the coming edge, clock it, then check just after.
  task automatic applyStimulus(input logic sel, input logic ev, input logic ci,
                               input int ei, input string tag);
    sb.push_back('{sel: sel, valid: ev, chk_idx: ci, idx: ei});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n_a = 1'b0; mode_a = 1'b0; ready_a = 1'b0; req_a = 8'hFF;
    rst_n_b = 1'b0; mode_b = 1'b1; ready_b = 1'b0; req_b = 5'h00;
    #2;

    applyStimulus(0, 0, 1, 0, "reset0");
    applyStimulus(0, 0, 1, 0, "reset1");
    rst_n_a = 1'b1; req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "idle");

    mode_a = 1'b0; req_a = 8'b0000_1010; ready_a = 1'b1;
    applyStimulus(0, 1, 1, 3, "fixed_first");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 3, "fixed_repeat");
    req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "fixed_drain");

    mode_a = 1'b1; req_a = 8'hFF;
    for (int i = 7; i >= 0; i--) applyStimulus(0, 1, 1, i, "rr_all");
    applyStimulus(0, 1, 1, 7, "rr_wrap");
    req_a = 8'b1000_0001;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 0, "rr_pair0");
      applyStimulus(0, 1, 1, 7, "rr_pair7");
    end
    req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "rr_drain");

    // Pointer now sits at 6, so a lone request from 5 is granted directly.
    req_a = 8'h20; ready_a = 1'b0;
    applyStimulus(0, 1, 1, 5, "bp_issue");
    req_a = 8'h80;
    for (int i = 0; i < 4; i++) begin
      mode_a = (i == 2) ? 1'b0 : 1'b1;
      applyStimulus(0, 1, 1, 5, "bp_hold");
    end
    mode_a = 1'b1; ready_a = 1'b1;
    applyStimulus(0, 1, 1, 7, "bp_next");
    req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "bp_drain");

    req_a = 8'h04; ready_a = 1'b0;
    applyStimulus(0, 1, 1, 2, "mid_issue");
    rst_n_a = 1'b0;
    applyStimulus(0, 0, 1, 0, "mid_reset");
    rst_n_a = 1'b1; req_a = 8'hFF; ready_a = 1'b1;
    applyStimulus(0, 1, 1, 7, "ptr_restart");
    applyStimulus(0, 1, 1, 6, "rr_after_reset");
    applyStimulus(0, 1, 1, 5, "rr_after_reset");
    mode_a = 1'b0; req_a = 8'h11;
    applyStimulus(0, 1, 1, 4, "switch_fixed");
    applyStimulus(0, 1, 1, 4, "fixed_regrant");
    req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "switch_drain");
    // Fixed-mode acceptances left the pointer at 5.
    mode_a = 1'b1; req_a = 8'hFF;
    applyStimulus(0, 1, 1, 5, "ptr_kept");
    req_a = 8'h00;
    applyStimulus(0, 0, 0, 0, "ptr_kept_drain");

    applyStimulus(1, 0, 1, 0, "n5_reset");
    rst_n_b = 1'b1; req_b = 5'h1F; ready_b = 1'b1;
    for (int i = 4; i >= 0; i--) applyStimulus(1, 1, 1, i, "n5_rr");
    applyStimulus(1, 1, 1, 4, "n5_wrap");
    for (int i = 3; i >= 0; i--) applyStimulus(1, 1, 1, i, "n5_rr2");
    req_b = 5'h00;
    applyStimulus(1, 0, 0, 0, "n5_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_arb_rr.md
# prio_arb_rr

Parametrised registered priority arbiter: selects one of `N` requesters and presents its index and one-hot grant through a valid/ready handshake. It supports a fixed-priority mode, where the highest index wins, and a round-robin mode with a rotating pointer. This is the sequential, N-wide successor to the team's 4-input combinational priority encoder. It sits between request sources and a shared downstream resource.

## Interface
Parameters:
- `N`, 8: number of requesters; ≥2; need not be a power of 2.
- `W`, `$clog2(N)`: index width; derived, do not override.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mode`  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- `req`  in  N  request vector; bit i = requester i.
- `gnt_ready`  in  1  downstream accepts the current grant.
- `gnt_valid`  out  1  grant outputs are valid.
- `gnt_idx`  out  W  granted index.
- `gnt_onehot`  out  N  one-hot form of `gnt_idx`.
- `busy`  out  1  high while a grant is pending; equals `gnt_valid`.

## Operation
- Internal state: FSM {IDLE, GRANT} and round-robin pointer `ptr[W-1:0]`.
  - `ptr` is the highest-priority index for the next round-robin search.
- Search, fixed mode: highest set bit of `req`.
- Search, round-robin mode: first set bit scanning `ptr`, `ptr-1`, …, 0, N-1, …, `ptr+1`, i.e. descending with wrap modulo N.
- IDLE:
  - `req==0`: stay in IDLE.
  - Otherwise: register the search result into `gnt_idx`/`gnt_onehot`, set `gnt_valid`, go to GRANT.
- GRANT: outputs are held stable while `gnt_ready==0`, regardless of `req` or `mode` changes. A grant, once issued, is never retracted or altered.
- Acceptance (`gnt_valid && gnt_ready`):
  - In mode 1, `ptr <= (gnt_idx==0) ? N-1 : gnt_idx-1`.
  - In mode 0, `ptr` is unchanged.
  - If `req!=0` in the same cycle, the next grant is computed from that `req` using the updated pointer and issued next cycle (back-to-back). `gnt_valid` stays high and the state stays GRANT.
  - If `req==0`, clear `gnt_valid` and go to IDLE.
- A requester may be re-granted immediately:
  - Always possible in fixed mode.
  - In round-robin mode, only when it is the sole requester.
- `mode` is sampled only at a search instant. Switching modes never resets `ptr`.
- `gnt_onehot` always equals `1 << gnt_idx` when `gnt_valid`. It is all-zero when `!gnt_valid`.
- Arithmetic:
  - Pointer decrement wraps to N-1, including non-power-of-2 N.
  - Index values ≥N are never produced.

## Timing
- Reset (`rst_n==0` at a rising edge):
  - State = IDLE, `gnt_valid=0`, `gnt_idx=0`, `gnt_onehot=0`, `busy=0`, `ptr=N-1`.
  - The initial round-robin search therefore matches fixed priority.
- Reset mid-grant: the pending grant is dropped at that edge, and `ptr` returns to N-1.
- Latency:
  - `req` asserted in IDLE at edge k gives `gnt_valid` high after edge k, visible in cycle k+1.
  - Request-to-grant latency is 1 cycle.
- Throughput: one grant per cycle with `gnt_ready` held high and continuous requests.
- All outputs are registered; there is no combinational path from `req`/`gnt_ready` to outputs.
- A `req` bit dropping while its grant is pending has no effect until acceptance.

## Test plan
- **Reset and idle:** `rst_n=0` for 2 cycles with `req=8'hFF`.
  - During reset: all outputs 0.
  - Release with `req=0`: `gnt_valid` stays 0.
- **Fixed priority:** `mode=0`, `req=8'b0000_1010`, `gnt_ready=1`.
  - Expect `gnt_idx=3` and `gnt_onehot=8'h08` one cycle later.
  - Then 3 repeatedly on every cycle while `req` is held.
- **Round-robin fairness:** `mode=1`, `req=8'hFF`, `gnt_ready=1`.
  - Expect `gnt_idx` sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
  - With `req=8'b1000_0001`: alternates 7,0,7,0.
- **Backpressure:** grant idx 5 issued, `gnt_ready=0` for 4 cycles while `req` changes to `8'h80`.
  - idx 5 is held for all 4 cycles.
  - On acceptance, next cycle shows idx 7.
- **Reset mid-operation and mode switch:**
  - `mode=1`, reset asserted while idx 2 is pending: `gnt_valid=0` next cycle, and `ptr` restarts at 7.
  - After several round-robin grants, switch to `mode=0` with `req=8'h11`: expect idx 4.
- **Non-power-of-2:** `N=5`, `mode=1`, `req=5'h1F`.
  - Sequence 4,3,2,1,0,4.
  - `gnt_idx` is never 5–7.
